// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core operand buffer: element/matrix/set
// typedefs, buffer FSM states and the linear-index to (matrix,row,col) decode.
package tensor_core_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int MATRIX_DIM   = 4;
  localparam int NUM_MATRICES = 2;
  localparam int ELEMS        = NUM_MATRICES * MATRIX_DIM * MATRIX_DIM;
  localparam int PTR_W        = $clog2(ELEMS + 1);
  localparam int MAT_W        = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1;
  localparam int DIM_W        = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;

  typedef logic [DATA_WIDTH-1:0]                  elem_t;
  typedef elem_t [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;
  typedef matrix_t [NUM_MATRICES-1:0]             operand_set_t;

  typedef enum logic {
    FILLING     = 1'b0,
    SHADOW_FULL = 1'b1
  } buf_state_e;

  typedef struct packed {
    logic [MAT_W-1:0] matrix;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
  } elem_idx_t;

  // Row-major placement of the serial element stream.
  function automatic elem_idx_t decode_index(input logic [PTR_W-1:0] p);
    elem_idx_t idx;
    int        pi;
    pi         = int'(p);
    idx.matrix = MAT_W'(pi / (MATRIX_DIM * MATRIX_DIM));
    idx.row    = DIM_W'((pi % (MATRIX_DIM * MATRIX_DIM)) / MATRIX_DIM);
    idx.col    = DIM_W'(pi % MATRIX_DIM);
    return idx;
  endfunction

endpackage

// File: rtl/tensor_core_operand_bank.sv
// One operand bank: single-element write port, every element visible in parallel.
module tensor_core_operand_bank
  import tensor_core_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [MAT_W-1:0]       matrix,
  input  logic [DIM_W-1:0]       row,
  input  logic [DIM_W-1:0]       col,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [NUM_MATRICES-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] rd
);

  operand_set_t mem;

  // NOTE: this storage is register-based and must read back zero after reset, so it is
  // reset like ordinary state; a RAM-style array would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[matrix][row][col] <= data;
    end
  end

  assign rd = mem;

endmodule

// File: rtl/tensor_core_operand_buffer.sv
// Ping-pong operand store: host fills the shadow bank serially, the active bank feeds the
// tensor core in parallel. Optional TENSOR_OPERAND_TRANSPOSE_EN adds column-major loading.
module tensor_core_operand_buffer
  import tensor_core_pkg::*;
(
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   write_valid_in,
  output logic                   write_ready_out,
  input  logic [DATA_WIDTH-1:0]  write_data_in,
  input  logic                   write_restart_in,
  output logic [PTR_W-1:0]       fill_count_out,
  output logic                   operands_valid_out,
  input  logic                   operands_ready_in,
`ifdef TENSOR_OPERAND_TRANSPOSE_EN
  input  logic                   transpose_in,
`endif
  output logic [NUM_MATRICES-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] read_data_out
);

  buf_state_e       state, state_next;
  logic [PTR_W-1:0] ptr;
  logic             bank_sel;
  logic             accept;
  logic             swap;
  elem_idx_t        idx;
  logic [DIM_W-1:0] wr_row, wr_col;
  operand_set_t     rd0, rd1;

  assign accept = (state == FILLING) && write_valid_in && !write_restart_in;
  // Restart outranks a pending swap so a host abort never promotes a stale set.
  assign swap   = (state == SHADOW_FULL) && !write_restart_in
                  && (!operands_valid_out || operands_ready_in);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= FILLING;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    if (write_restart_in) begin
      state_next = FILLING;
    end else begin
      unique case (state)
        FILLING:     if (accept && ptr == PTR_W'(ELEMS - 1)) state_next = SHADOW_FULL;
        SHADOW_FULL: if (swap) state_next = FILLING;
        default:     state_next = FILLING;
      endcase
    end
  end

  always_comb begin
    write_ready_out = (state == FILLING);
    fill_count_out  = ptr;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ptr                <= '0;
      bank_sel           <= 1'b0;
      operands_valid_out <= 1'b0;
    end else begin
      if (write_restart_in || swap) begin
        ptr <= '0;
      end else if (accept) begin
        ptr <= ptr + 1'b1;
      end

      if (swap) begin
        bank_sel           <= ~bank_sel;
        operands_valid_out <= 1'b1;
      end else if (operands_valid_out && operands_ready_in) begin
        operands_valid_out <= 1'b0;
      end
    end
  end

  assign idx = decode_index(ptr);

`ifdef TENSOR_OPERAND_TRANSPOSE_EN
  assign wr_row = transpose_in ? idx.col : idx.row;
  assign wr_col = transpose_in ? idx.row : idx.col;
`else
  assign wr_row = idx.row;
  assign wr_col = idx.col;
`endif

  // The shadow bank is the one not selected for reading.
  tensor_core_operand_bank u_bank0 (
    .clk    (clock_in),
    .rst_n  (reset_n_in),
    .we     (accept && bank_sel),
    .matrix (idx.matrix),
    .row    (wr_row),
    .col    (wr_col),
    .data   (write_data_in),
    .rd     (rd0)
  );

  tensor_core_operand_bank u_bank1 (
    .clk    (clock_in),
    .rst_n  (reset_n_in),
    .we     (accept && !bank_sel),
    .matrix (idx.matrix),
    .row    (wr_row),
    .col    (wr_col),
    .data   (write_data_in),
    .rd     (rd1)
  );

  assign read_data_out = bank_sel ? rd1 : rd0;

endmodule

// File: tb/tb_tensor_core_operand_buffer.sv
// Directed bench for tensor_core_operand_buffer; define TENSOR_OPERAND_TRANSPOSE_EN
// on both DUT and bench to also exercise column-major loading.
module tb_tensor_core_operand_buffer;
  import tensor_core_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               write_valid;
  logic               write_ready;
  logic [7:0]         write_data;
  logic               write_restart;
  logic [PTR_W-1:0]   fill_count;
  logic               operands_valid;
  logic               operands_ready;
  operand_set_t       read_data;
  operand_set_t       exp_set;
  operand_set_t       old_set;
  int                 errors;
  int                 checks;
`ifdef TENSOR_OPERAND_TRANSPOSE_EN
  logic               transpose;
`endif

  tensor_core_operand_buffer dut (
    .clock_in           (clk),
    .reset_n_in         (rst_n),
    .write_valid_in     (write_valid),
    .write_ready_out    (write_ready),
    .write_data_in      (write_data),
    .write_restart_in   (write_restart),
    .fill_count_out     (fill_count),
    .operands_valid_out (operands_valid),
    .operands_ready_in  (operands_ready),
`ifdef TENSOR_OPERAND_TRANSPOSE_EN
    .transpose_in       (transpose),
`endif
    .read_data_out      (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    write_valid = 1'b1;
    write_data  = d;
    step();
    write_valid = 1'b0;
  endtask

  // Expected set where element p (row-major) holds base+p.
  function automatic operand_set_t ramp_set(input int base);
    operand_set_t s;
    for (int p = 0; p < 32; p++) s[p / 16][(p % 16) / 4][p % 4] = 8'(base + p);
    return s;
  endfunction

  initial begin
    errors         = 0;
    checks         = 0;
    rst_n          = 1'b0;
    write_valid    = 1'b0;
    write_data     = '0;
    write_restart  = 1'b0;
    operands_ready = 1'b0;
`ifdef TENSOR_OPERAND_TRANSPOSE_EN
    transpose      = 1'b0;
`endif

    // Reset state
    #12;
    check("rst_write_ready", 256'(write_ready), 256'(1));
    check("rst_valid", 256'(operands_valid), 256'(0));
    check("rst_fill_count", 256'(fill_count), 256'(0));
    check("rst_read_data", 256'(read_data), 256'(0));
    #5 rst_n = 1'b1;
    step();

    // First set 1..32 with the consumer ready
    operands_ready = 1'b1;
    for (int i = 0; i < 32; i++) beat(8'(i + 1));
    check("full1_fill_count", 256'(fill_count), 256'(32));
    check("full1_write_ready", 256'(write_ready), 256'(0));
    check("full1_valid_not_yet", 256'(operands_valid), 256'(0));
    step();
    operands_ready = 1'b0;
    check("set1_valid", 256'(operands_valid), 256'(1));
    check("set1_elem_000", 256'(read_data[0][0][0]), 256'(1));
    check("set1_elem_133", 256'(read_data[1][3][3]), 256'(32));
    check("set1_full", 256'(read_data), 256'(ramp_set(1)));
    check("set1_fill_reset", 256'(fill_count), 256'(0));
    check("set1_write_ready", 256'(write_ready), 256'(1));

    // Second set 100..131 while the active set is held
    for (int i = 0; i < 32; i++) beat(8'(100 + i));
    check("full2_write_ready", 256'(write_ready), 256'(0));
    step();
    step();
    check("hold_valid", 256'(operands_valid), 256'(1));
    check("hold_data", 256'(read_data), 256'(ramp_set(1)));
    check("hold_fill_count", 256'(fill_count), 256'(32));
    operands_ready = 1'b1;
    step();
    operands_ready = 1'b0;
    check("swap2_valid_no_bubble", 256'(operands_valid), 256'(1));
    check("swap2_data", 256'(read_data), 256'(ramp_set(100)));
    check("swap2_write_ready", 256'(write_ready), 256'(1));

    // Restart after 10 beats, including a beat on the restart cycle
    for (int i = 0; i < 10; i++) beat(8'(50 + i));
    check("partial_fill_count", 256'(fill_count), 256'(10));
    write_restart = 1'b1;
    beat(8'hEE);
    write_restart = 1'b0;
    check("restart_fill_count", 256'(fill_count), 256'(0));
    check("restart_write_ready", 256'(write_ready), 256'(1));
    check("restart_valid_kept", 256'(operands_valid), 256'(1));
    for (int i = 0; i < 32; i++) beat(8'hA5);
    check("a5_fill_count", 256'(fill_count), 256'(32));
    check("a5_active_untouched", 256'(read_data), 256'(ramp_set(100)));
    operands_ready = 1'b1;
    step();
    operands_ready = 1'b0;
    exp_set = '0;
    for (int p = 0; p < 32; p++) exp_set[p / 16][(p % 16) / 4][p % 4] = 8'hA5;
    check("a5_data", 256'(read_data), 256'(exp_set));
    check("a5_valid", 256'(operands_valid), 256'(1));

    // Restart in SHADOW_FULL while the swap condition also holds: restart wins
    for (int i = 0; i < 32; i++) beat(8'h07);
    check("full4_write_ready", 256'(write_ready), 256'(0));
    old_set        = exp_set;
    write_restart  = 1'b1;
    operands_ready = 1'b1;
    beat(8'h3C);
    write_restart  = 1'b0;
    operands_ready = 1'b0;
    check("rw_fill_count", 256'(fill_count), 256'(0));
    check("rw_write_ready", 256'(write_ready), 256'(1));
    check("rw_no_swap_data", 256'(read_data), 256'(old_set));
    check("rw_consumed_valid", 256'(operands_valid), 256'(0));
    step();
    check("rw_still_no_swap", 256'(operands_valid), 256'(0));

    // Asynchronous reset mid-fill with a beat on the bus
    for (int i = 0; i < 5; i++) beat(8'(200 + i));
    write_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_write_ready", 256'(write_ready), 256'(1));
    check("arst_valid", 256'(operands_valid), 256'(0));
    check("arst_fill_count", 256'(fill_count), 256'(0));
    check("arst_read_data", 256'(read_data), 256'(0));
    #2 rst_n = 1'b1;
    write_valid = 1'b0;
    step();
    check("post_rst_fill_count", 256'(fill_count), 256'(0));

`ifdef TENSOR_OPERAND_TRANSPOSE_EN
    // Column-major load of 0..15 into matrix 0
    transpose = 1'b1;
    for (int i = 0; i < 32; i++) beat(8'((i < 16) ? i : 0));
    transpose = 1'b0;
    step();
    check("tr_valid", 256'(operands_valid), 256'(1));
    check("tr_elem_010", 256'(read_data[0][1][0]), 256'(1));
    check("tr_elem_001", 256'(read_data[0][0][1]), 256'(4));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
